// File: rtl/clk_div_prog.sv
// -----------------------------------------------------------------------------
// clk_div_prog
//   Runtime-programmable integer clock divider. It produces a 50 % duty divided
//   clock for any divisor from 2 to 2^WIDTH-1, odd or even. It also has run/stop
//   control and a divisor change that is free of glitches because it only takes
//   effect at a period boundary. A one-cycle tick marks each rising edge of
//   clk_out, so logic in the clk_in domain never has to sample the divided clock.
//
// Ports
//   clk_in      in   source clock (posedge state, negedge odd half-cycle reg)
//   rst         in   asynchronous active-low reset
//   en          in   run enable, sampled on posedge clk_in
//   div_val     in   [WIDTH-1:0] new divisor N
//   div_load    in   single-cycle request to capture div_val
//   clk_out     out  divided clock, period N x clk_in
//   tick        out  one-cycle pulse with each clk_out rising edge
//   div_pending out  a captured divisor waits for the next period start
//   div_err     out  one-cycle pulse on a rejected load (div_val < 2)
// -----------------------------------------------------------------------------
module clk_div_prog #(
    parameter int WIDTH     = 8,
    parameter int DIV_RESET = 2
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] div_val,
    input  logic             div_load,
    output logic             clk_out,
    output logic             tick,
    output logic             div_pending,
    output logic             div_err
);

    localparam logic [WIDTH-1:0] ZERO_C  = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_C   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] TWO_C   = {{(WIDTH-2){1'b0}}, 2'b10};
    localparam logic [WIDTH-1:0] RESET_C = WIDTH'(DIV_RESET);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state_r,   state_nxt_s;
    logic [WIDTH-1:0] cur_n_r,   cur_n_s;
    logic [WIDTH-1:0] nxt_n_r,   nxt_n_s;
    logic             nxt_vld_r, nxt_vld_s;
    logic [WIDTH-1:0] cnt_r,     cnt_s;
    logic             pos_r,     pos_s;
    logic             tick_r,    tick_s;
    logic             err_r,     err_s;
    logic             neg_r;

    logic             last_s;      // counter is at cur_n-1 (wrap edge pending)
    logic             start_s;     // this edge begins a new period
    logic [WIDTH-1:0] cnt_inc_s;
    logic [WIDTH-1:0] half_s;

    assign last_s    = (cnt_r == (cur_n_r - ONE_C));
    assign cnt_inc_s = cnt_r + ONE_C;
    assign half_s    = cur_n_r >> 1;

    // Next-state logic: run/stop sequencing, counter, divisor apply and load.
    always_comb begin
        state_nxt_s = state_r;
        cur_n_s     = cur_n_r;
        nxt_n_s     = nxt_n_r;
        nxt_vld_s   = nxt_vld_r;
        cnt_s       = cnt_r;
        pos_s       = pos_r;
        tick_s      = 1'b0;
        err_s       = 1'b0;
        start_s     = 1'b0;

        case (state_r)
            ST_IDLE: begin
                cnt_s = ZERO_C;
                pos_s = 1'b0;
                if (en) begin
                    state_nxt_s = ST_RUN;
                    start_s     = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_s) begin
                    // en is only looked at here, so a mid-period drop
                    // never truncates the current period.
                    cnt_s = ZERO_C;
                    if (en) begin
                        state_nxt_s = ST_RUN;
                        start_s     = 1'b1;
                    end else begin
                        state_nxt_s = ST_IDLE;
                        pos_s       = 1'b0;
                    end
                end else begin
                    state_nxt_s = ST_RUN;
                    cnt_s       = cnt_inc_s;
                    pos_s       = (cnt_inc_s < half_s);
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_s       = ZERO_C;
                pos_s       = 1'b0;
            end
        endcase

        // A period start always begins high: floor(N/2) >= 1 for any N >= 2.
        if (start_s) begin
            pos_s  = 1'b1;
            tick_s = 1'b1;
            if (nxt_vld_r) begin
                cur_n_s   = nxt_n_r;
                nxt_vld_s = 1'b0;
            end else begin
                cur_n_s = cur_n_r;
            end
        end else begin
            tick_s = 1'b0;
        end

        // The load is evaluated after the apply, so a load on a period-start
        // edge becomes the new pending value while the old one is consumed.
        if (div_load) begin
            if (div_val < TWO_C) begin
                err_s = 1'b1;
            end else begin
                nxt_n_s   = div_val;
                nxt_vld_s = 1'b1;
            end
        end else begin
            err_s = 1'b0;
        end
    end

    // Posedge state register.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            cur_n_r   <= RESET_C;
            nxt_n_r   <= RESET_C;
            nxt_vld_r <= 1'b0;
            cnt_r     <= ZERO_C;
            pos_r     <= 1'b0;
            tick_r    <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            cur_n_r   <= cur_n_s;
            nxt_n_r   <= nxt_n_s;
            nxt_vld_r <= nxt_vld_s;
            cnt_r     <= cnt_s;
            pos_r     <= pos_s;
            tick_r    <= tick_s;
            err_r     <= err_s;
        end
    end

    // Odd-divisor half-cycle stretch: delays pos_r by half a clk_in period so
    // the OR below adds exactly 0.5 cycle of high time.
    always_ff @(negedge clk_in or negedge rst) begin
        if (!rst) begin
            neg_r <= 1'b0;
        end else if (cur_n_r[0]) begin
            neg_r <= pos_r;
        end else begin
            neg_r <= 1'b0;
        end
    end

    assign clk_out     = pos_r | neg_r;
    assign tick        = tick_r;
    assign div_pending = nxt_vld_r;
    assign div_err     = err_r;

endmodule
